// File: rtl/ram4k_arb_pkg.sv
// Shared types and defaults for the RAM4K two-port arbiter.
package ram4k_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int LOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKED_P0 = 2'd1,
        LOCKED_P1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t lock_state(input logic port);
        return port ? LOCKED_P1 : LOCKED_P0;
    endfunction

endpackage

// File: rtl/ram4k_arb_grant.sv
// Combinational winner select for the RAM4K arbiter.
// RAM4K_ARB_FIXED_PRIO_EN: port 0 always wins when unlocked; no rr_ptr input.
module ram4k_arb_grant
    import ram4k_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  arb_state_t state,
`ifndef RAM4K_ARB_FIXED_PRIO_EN
    input  logic       rr_ptr,
`endif
    output logic       grant0,
    output logic       grant1
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            LOCKED_P0: grant0 = valid0;
            LOCKED_P1: grant1 = valid1;
            default: begin
`ifdef RAM4K_ARB_FIXED_PRIO_EN
                grant0 = valid0;
                grant1 = valid1 & ~valid0;
`else
                if (valid0 && valid1) begin
                    grant0 = ~rr_ptr;
                    grant1 = rr_ptr;
                end else begin
                    grant0 = valid0;
                    grant1 = valid1;
                end
`endif
            end
        endcase
    end

endmodule

// File: rtl/ram4k_arbiter.sv
// Two-port arbiter in front of an unmodified RAM4K: one access per cycle,
// registered read response, bounded lock for atomic RMW.
// RAM4K_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
//
// state     | meaning
// UNLOCKED  | either port may be granted (round-robin / fixed priority)
// LOCKED_P0 | only port 0 may be granted, lock_cnt counts held cycles
// LOCKED_P1 | only port 1 may be granted, lock_cnt counts held cycles
module ram4k_arbiter
    import ram4k_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    input  logic              p0_write,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    input  logic              p1_write,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int CNT_W = LOCK_CNT_W + 1;
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

    arb_state_t            state;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0]      lock_next;
    logic                  lock_expire;
    logic                  owner_release;
    logic                  grant0, grant1;
    logic                  accept0, accept1;
    logic                  rd0, rd1;
    logic [ADDR_W-1:0]     last_addr;
`ifndef RAM4K_ARB_FIXED_PRIO_EN
    logic                  rr_ptr;
`endif

    ram4k_arb_grant u_grant (
        .valid0 (p0_valid),
        .valid1 (p1_valid),
        .state  (state),
`ifndef RAM4K_ARB_FIXED_PRIO_EN
        .rr_ptr (rr_ptr),
`endif
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign p0_ready = rst_n & grant0;
    assign p1_ready = rst_n & grant1;
    assign accept0  = p0_valid & p0_ready;
    assign accept1  = p1_valid & p1_ready;
    assign rd0      = accept0 & ~p0_write;
    assign rd1      = accept1 & ~p1_write;

    // With no winner the RAM keeps seeing the last granted address.
    assign ram_address = accept1 ? p1_addr : (accept0 ? p0_addr : last_addr);
    assign ram_in      = accept1 ? p1_wdata : p0_wdata;
    assign ram_load    = (accept0 & p0_write) | (accept1 & p1_write);

    // Release fires at the edge where the held count would reach LOCK_MAX.
    assign lock_next     = {1'b0, lock_cnt} + CNT_W'(1);
    assign lock_expire   = lock_next >= LOCK_LIM;
    assign owner_release = (state == LOCKED_P0) ? (accept0 & ~p0_lock)
                                                : (accept1 & ~p1_lock);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= UNLOCKED;
            lock_cnt  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            last_addr <= '0;
`ifndef RAM4K_ARB_FIXED_PRIO_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            p0_rvalid <= rd0;
            p1_rvalid <= rd1;
            if (rd0) p0_rdata <= ram_out;
            if (rd1) p1_rdata <= ram_out;
            if (accept0 | accept1) last_addr <= ram_address;
`ifndef RAM4K_ARB_FIXED_PRIO_EN
            if (accept0)      rr_ptr <= 1'b1;
            else if (accept1) rr_ptr <= 1'b0;
`endif
            case (state)
                UNLOCKED: begin
                    if ((accept0 & p0_lock) | (accept1 & p1_lock)) begin
                        state    <= lock_state(accept1);
                        lock_cnt <= LOCK_CNT_W'(1);
                    end
                end
                LOCKED_P0, LOCKED_P1: begin
                    if (owner_release) begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
                    end else if (lock_expire) begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
`ifndef RAM4K_ARB_FIXED_PRIO_EN
                        rr_ptr   <= (state == LOCKED_P0);
`endif
                    end else if (lock_cnt != '1) begin
                        lock_cnt <= lock_next[LOCK_CNT_W-1:0];
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Self-checking bench for ram4k_arbiter: directed scenarios then random traffic,
// compared against a transaction-level model of the arbitration rules.
module tb_ram4k_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int LMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1:0]    v, wr, lk;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd [2];

    logic          p0_ready, p0_rvalid, p1_ready, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_in, ram_out;
    logic          ram_load;

    ram4k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_valid    (v[0]),
        .p0_write    (wr[0]),
        .p0_lock     (lk[0]),
        .p0_addr     (addr[0]),
        .p0_wdata    (wd[0]),
        .p0_ready    (p0_ready),
        .p0_rvalid   (p0_rvalid),
        .p0_rdata    (p0_rdata),
        .p1_valid    (v[1]),
        .p1_write    (wr[1]),
        .p1_lock     (lk[1]),
        .p1_addr     (addr[1]),
        .p1_wdata    (wd[1]),
        .p1_ready    (p1_ready),
        .p1_rvalid   (p1_rvalid),
        .p1_rdata    (p1_rdata),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    // RAM4K stand-in: combinational read, write on the edge, plus a preload path.
    logic [DW-1:0] mem [4096];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en)         mem[pl_addr]     <= pl_data;
        else if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    // Reference model state.
    logic [DW-1:0] ref_mem [4096];
    int            owner, age, pref;
    bit            last_ok;
    logic [AW-1:0] last_a;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd [2];
    bit   [1:0]    acc;
    int            n_checks = 0;
    int            n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        age     = 0;
        pref    = 0;
        last_ok = 1'b0;
        exp_rv  = 2'b00;
        exp_rd  = '{default: '0};
    endtask

    function automatic int winner();
        if (owner >= 0) return v[owner] ? owner : -1;
`ifdef RAM4K_ARB_FIXED_PRIO_EN
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
`else
        if (v == 2'b11) return pref;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
`endif
    endfunction

    task automatic model_step(input int w);
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_rv = 2'b00;
        if (w >= 0) begin
            if (!wr[w]) begin
                exp_rv[w] = 1'b1;
                exp_rd[w] = ref_mem[addr[w]];
            end else begin
                ref_mem[addr[w]] = wd[w];
            end
            last_a  = addr[w];
            last_ok = 1'b1;
            pref    = 1 - w;
        end
        if (owner < 0) begin
            if (w >= 0 && lk[w]) begin
                owner = w;
                age   = 1;
            end
        end else if (w == owner && !lk[w]) begin
            owner = -1;
        end else begin
            age++;
            if (age >= LMAX) begin
                pref  = 1 - owner;
                owner = -1;
            end
        end
    endtask

    // One clock: check request-side outputs before the edge, response after it.
    task automatic cyc();
        int w;
        #2;
        w = winner();
        if (!rst_n) begin
            chk("rst_ready0", 32'(p0_ready), 32'(0));
            chk("rst_ready1", 32'(p1_ready), 32'(0));
            chk("rst_load", 32'(ram_load), 32'(0));
        end else begin
            chk("ready0", 32'(p0_ready), 32'(w == 0));
            chk("ready1", 32'(p1_ready), 32'(w == 1));
            chk("load", 32'(ram_load), (w >= 0) ? 32'(wr[w]) : 32'(0));
            if (w >= 0) begin
                chk("ram_address", 32'(ram_address), 32'(addr[w]));
                if (wr[w]) chk("ram_in", 32'(ram_in), 32'(wd[w]));
            end else if (last_ok) begin
                chk("hold_address", 32'(ram_address), 32'(last_a));
            end
        end
        acc = 2'b00;
        if (rst_n && w >= 0) acc[w] = 1'b1;
        @(posedge clk);
        #1;
        model_step(w);
        chk("rvalid0", 32'(p0_rvalid), 32'(exp_rv[0]));
        chk("rvalid1", 32'(p1_rvalid), 32'(exp_rv[1]));
        chk("rdata0", 32'(p0_rdata), 32'(exp_rd[0]));
        chk("rdata1", 32'(p1_rdata), 32'(exp_rd[1]));
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 12'h000;
            1:       return 12'hFFF;
            default: return AW'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst_n   = 1'b0;
        v       = 2'b00;
        wr      = 2'b00;
        lk      = 2'b00;
        addr    = '{default: '0};
        wd      = '{default: '0};
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        acc     = 2'b00;
        model_reset();
        @(negedge clk);

        pl_en = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            pl_addr    = AW'(i);
            pl_data    = DW'($urandom);
            ref_mem[i] = pl_data;
            @(negedge clk);
        end
        pl_en = 1'b0;

        // Reset hold with both ports writing, then release.
        v    = 2'b11;
        wr   = 2'b11;
        addr = '{12'h005, 12'h006};
        wd   = '{16'h1111, 16'h2222};
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        v = 2'b00;
        cyc();

        // Contention: both read continuously.
        v    = 2'b11;
        wr   = 2'b00;
        addr = '{12'h010, 12'h020};
        repeat (6) cyc();
        v = 2'b00;
        cyc();

        // Write then read at both ends of the address range.
        v       = 2'b10;
        wr[1]   = 1'b1;
        addr[1] = 12'hFFF;
        wd[1]   = 16'hBEEF;
        cyc();
        wr[1] = 1'b0;
        cyc();
        v = 2'b00;
        cyc();
        chk("t3_rdata_fff", 32'(p1_rdata), 32'(16'hBEEF));
        v       = 2'b01;
        wr[0]   = 1'b1;
        addr[0] = 12'h000;
        wd[0]   = 16'h5A5A;
        cyc();
        wr[0] = 1'b0;
        cyc();
        v = 2'b00;
        cyc();
        chk("t3_rdata_000", 32'(p0_rdata), 32'(16'h5A5A));

        // Atomic RMW: P1 goes first so P0 is favoured when the lock starts.
        v       = 2'b10;
        addr[1] = 12'h200;
        cyc();
        v       = 2'b11;
        wr      = 2'b00;
        lk      = 2'b01;
        addr[0] = 12'h100;
        cyc();
        wr[0] = 1'b1;
        lk[0] = 1'b0;
        wd[0] = 16'h0101;
        cyc();
        v[0] = 1'b0;
        cyc();
        v = 2'b00;
        cyc();

        // Lock timeout: owner drops valid, P1 waits for forced release.
        v       = 2'b01;
        wr      = 2'b00;
        lk      = 2'b01;
        addr[0] = 12'h123;
        cyc();
        v  = 2'b10;
        lk = 2'b00;
        repeat (5) cyc();
        v = 2'b00;
        cyc();

        // Reset while locked with a read response pending.
        v       = 2'b01;
        lk      = 2'b01;
        addr[0] = 12'h0FF;
        cyc();
        rst_n = 1'b0;
        v     = 2'b10;
        lk    = 2'b00;
        cyc();
        rst_n = 1'b1;
        cyc();
        v = 2'b00;
        cyc();

        // Random traffic obeying the hold-while-not-ready rule.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(v[p] && !acc[p])) begin
                    v[p]    = ($urandom_range(0, 3) != 0);
                    wr[p]   = 1'($urandom_range(0, 1));
                    lk[p]   = ($urandom_range(0, 7) == 0);
                    addr[p] = pick_addr();
                    wd[p]   = DW'($urandom);
                end
            end
            rst_n = ($urandom_range(0, 99) != 0);
            cyc();
        end
        rst_n = 1'b1;
        v     = 2'b00;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
